// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser plus a per-button debounce/hold FSM
// producing a clean level, press/release/long pulses and a press-driven toggle.
module button_conditioner #(
    parameter int unsigned N_BTN           = 2,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned HOLD_CYCLES     = 50_000_000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [N_BTN-1:0] btn_raw_i,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] btn_press_o,
    output logic [N_BTN-1:0] btn_release_o,
    output logic [N_BTN-1:0] btn_long_o,
    output logic [N_BTN-1:0] btn_toggle_o
);

    localparam int unsigned DcntW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HcntW = $clog2(HOLD_CYCLES);
    localparam logic [DcntW-1:0] DcntMax = DcntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HcntW-1:0] HcntMax = HcntW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDbPress,
        StPressed,
        StHeld,
        StDbRelease
    } state_e;

    logic [N_BTN-1:0] s1_q, s2_q;

    // Polarity is normalised before the synchroniser so 1 always means pressed.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn_raw_i ^ {N_BTN{ACTIVE_LOW}};
            s2_q <= s1_q;
        end
    end

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        state_e           state_q, state_d;
        logic [DcntW-1:0] dcnt_q, dcnt_d;
        logic [HcntW-1:0] hcnt_q, hcnt_d;
        logic             from_held_q, from_held_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             long_q, long_d;
        logic             toggle_q, toggle_d;
        logic             s2;

        assign s2 = s2_q[gi];

        always_comb begin
            state_d     = state_q;
            dcnt_d      = dcnt_q;
            hcnt_d      = hcnt_q;
            from_held_d = from_held_q;
            level_d     = level_q;
            press_d     = 1'b0;
            release_d   = 1'b0;
            long_d      = 1'b0;
            toggle_d    = toggle_q;
            unique case (state_q)
                StIdle: begin
                    if (s2) begin
                        state_d = StDbPress;
                        dcnt_d  = '0;
                    end
                end
                StDbPress: begin
                    if (!s2) begin
                        state_d = StIdle;
                    end else if (dcnt_q == DcntMax) begin
                        state_d  = StPressed;
                        press_d  = 1'b1;
                        level_d  = 1'b1;
                        hcnt_d   = '0;
                        toggle_d = ~toggle_q;
                    end else begin
                        dcnt_d = dcnt_q + DcntW'(1);
                    end
                end
                StPressed: begin
                    if (!s2) begin
                        state_d     = StDbRelease;
                        dcnt_d      = '0;
                        from_held_d = 1'b0;
                    end else if (hcnt_q == HcntMax) begin
                        state_d = StHeld;
                        long_d  = 1'b1;
                    end else begin
                        hcnt_d = hcnt_q + HcntW'(1);
                    end
                end
                StHeld: begin
                    if (!s2) begin
                        state_d     = StDbRelease;
                        dcnt_d      = '0;
                        from_held_d = 1'b1;
                    end
                end
                StDbRelease: begin
                    // A release bounce resumes where it left off; hcnt is untouched.
                    if (s2) begin
                        state_d = from_held_q ? StHeld : StPressed;
                    end else if (dcnt_q == DcntMax) begin
                        state_d   = StIdle;
                        release_d = 1'b1;
                        level_d   = 1'b0;
                    end else begin
                        dcnt_d = dcnt_q + DcntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                state_q     <= StIdle;
                dcnt_q      <= '0;
                hcnt_q      <= '0;
                from_held_q <= 1'b0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                long_q      <= 1'b0;
                toggle_q    <= 1'b0;
            end else begin
                state_q     <= state_d;
                dcnt_q      <= dcnt_d;
                hcnt_q      <= hcnt_d;
                from_held_q <= from_held_d;
                level_q     <= level_d;
                press_q     <= press_d;
                release_q   <= release_d;
                long_q      <= long_d;
                toggle_q    <= toggle_d;
            end
        end

        assign btn_level_o[gi]   = level_q;
        assign btn_press_o[gi]   = press_q;
        assign btn_release_o[gi] = release_q;
        assign btn_long_o[gi]    = long_q;
        assign btn_toggle_o[gi]  = toggle_q;
    end

endmodule
